// File: rtl/divider_if.sv
// Request/response bundle between an execution unit and the iterative divider.
interface divider_if #(
  parameter int unsigned WIDTH_N = 32,
  parameter int unsigned WIDTH_D = 32
);
  logic               enable;
  logic               start;
  logic               is_signed;
  logic [WIDTH_N-1:0] a;
  logic [WIDTH_D-1:0] b;
  logic               busy;
  logic               valid;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               div_by_zero;

  // Requester side: issues operands, observes the result.
  modport master (
    output enable, start, is_signed, a, b,
    input  busy, valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  enable, start, is_signed, a, b,
    output busy, valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per
// enabled clock, fixed latency of WIDTH_N+1 enabled edges.
// Optional macro DIVIDER_DBZ_FAST_EN: a zero divisor skips the iterations and
// completes in one edge after start.
module divider #(
  parameter int unsigned WIDTH_N = 32,
  parameter int unsigned WIDTH_D = 32
) (
  input logic      clk,
  input logic      rst_n,
  divider_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(WIDTH_N);
  localparam int unsigned REM_W  = WIDTH_D + 1;
  localparam int unsigned DIFF_W = WIDTH_D + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH_N-1:0] dvd_q, dvd_d;     // |a| shifting out, quotient shifting in
  logic [WIDTH_D-1:0] bmag_q, bmag_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [WIDTH_N-1:0] quotient_q, quotient_d;
  logic [WIDTH_D-1:0] remainder_q, remainder_d;
  logic               div_by_zero_q, div_by_zero_d;

  logic               a_neg_c;
  logic               b_neg_c;
  logic [WIDTH_N-1:0] a_mag_c;
  logic [WIDTH_D-1:0] b_mag_c;
  logic [REM_W-1:0]   shifted_c;
  logic [DIFF_W-1:0]  diff_c;
  logic               borrow_c;
  logic [WIDTH_N-1:0] quo_fix_c;
  logic [WIDTH_D-1:0] rem_fix_c;

  // Operand magnitudes, restoring step and final sign correction.
  always_comb begin
    a_neg_c   = bus.is_signed & bus.a[WIDTH_N-1];
    b_neg_c   = bus.is_signed & bus.b[WIDTH_D-1];
    a_mag_c   = a_neg_c ? (~bus.a + WIDTH_N'(1)) : bus.a;
    b_mag_c   = b_neg_c ? (~bus.b + WIDTH_D'(1)) : bus.b;
    shifted_c = {rem_q[WIDTH_D-1:0], dvd_q[WIDTH_N-1]};
    diff_c    = {1'b0, shifted_c} - {2'b00, bmag_q};
    borrow_c  = diff_c[DIFF_W-1];
    // A zero divisor leaves the low bits of |a| in rem, so the sign fix
    // below reproduces the raw dividend as the remainder.
    quo_fix_c = dbz_q ? {WIDTH_N{1'b1}}
              : ((sa_q ^ sb_q) ? (~dvd_q + WIDTH_N'(1)) : dvd_q);
    rem_fix_c = sa_q ? WIDTH_D'(~rem_q + REM_W'(1)) : WIDTH_D'(rem_q);
  end

  // Next-state and next-output logic; enable low holds everything.
  always_comb begin
    state_d       = state_q;
    sa_d          = sa_q;
    sb_d          = sb_q;
    dbz_d         = dbz_q;
    dvd_d         = dvd_q;
    bmag_d        = bmag_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    valid_d       = valid_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    if (bus.enable) begin
      valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sa_d   = a_neg_c;
            sb_d   = b_neg_c;
            dvd_d  = a_mag_c;
            bmag_d = b_mag_c;
            rem_d  = '0;
            cnt_d  = CNT_W'(WIDTH_N - 1);
            dbz_d  = (bus.b == '0);
            busy_d = 1'b1;
`ifdef DIVIDER_DBZ_FAST_EN
            if (bus.b == '0) begin
              rem_d   = REM_W'(a_mag_c);
              state_d = FIX;
            end else begin
              state_d = CALC;
            end
`else
            state_d = CALC;
`endif
          end
        end
        CALC: begin
          rem_d = borrow_c ? shifted_c : diff_c[REM_W-1:0];
          dvd_d = {dvd_q[WIDTH_N-2:0], ~borrow_c};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quotient_d    = quo_fix_c;
          remainder_d   = rem_fix_c;
          div_by_zero_d = dbz_q;
          valid_d       = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      dbz_q         <= 1'b0;
      dvd_q         <= '0;
      bmag_q        <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      dbz_q         <= dbz_d;
      dvd_q         <= dvd_d;
      bmag_q        <= bmag_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the 8-bit divider with an arithmetic reference model.
module tb_divider;

`ifdef DIVIDER_DBZ_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  divider_if #(.WIDTH_N(8), .WIDTH_D(8)) bus ();

  divider #(.WIDTH_N(8), .WIDTH_D(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic.
  task automatic ref_div(input logic sg, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z);
    int ai, bi;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else if (sg) begin
      ai = int'($signed(a));
      bi = int'($signed(b));
      q = 8'(ai / bi); r = 8'(ai % bi); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Cycle model: a request occupies the unit for a fixed count of enabled edges.
  int         m_left = 0;
  logic       m_busy = 1'b0, m_valid = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  logic [7:0] m_q = 8'h00, m_r = 8'h00, p_q = 8'h00, p_r = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_busy = 1'b0; m_valid = 1'b0;
      m_q = 8'h00; m_r = 8'h00; m_dbz = 1'b0;
    end else if (bus.enable) begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_valid = 1'b1;
          m_q = p_q; m_r = p_r; m_dbz = p_dbz;
        end
      end else if (bus.start) begin
        ref_div(bus.is_signed, bus.a, bus.b, p_q, p_r, p_dbz);
        m_left = p_dbz ? DBZ_LAT : 9;
        m_busy = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_busy", 32'(bus.busy), 32'(m_busy));
    check("cyc_valid", 32'(bus.valid), 32'(m_valid));
    check("cyc_quot", 32'(bus.quotient), 32'(m_q));
    check("cyc_rem", 32'(bus.remainder), 32'(m_r));
    check("cyc_dbz", 32'(bus.div_by_zero), 32'(m_dbz));
    check("cyc_busy_and_valid", 32'(bus.busy & bus.valid), 32'd0);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic issue(input logic sg, input logic [7:0] a, input logic [7:0] b);
    bus.is_signed = sg;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for valid (bounded) from the post-E0 point and checks literals.
  task automatic wait_result(input string name, input logic [7:0] eq, input logic [7:0] er,
                             input logic ed, input int elat, input int stall_at, input int poke_at);
    int lat = 0;
    int busy_cnt = 0;
    while (!bus.valid && lat < 40) begin
      busy_cnt += int'(bus.busy);
      if (lat == stall_at) bus.enable = 1'b0;
      if (lat == stall_at + 3) bus.enable = 1'b1;
      if (lat == poke_at) begin
        bus.a = 8'h11; bus.b = 8'h01; bus.start = 1'b1;
      end
      if (lat == poke_at + 1) bus.start = 1'b0;
      tick();
      lat++;
    end
    bus.enable = 1'b1;
    bus.start = 1'b0;
    check({name, "_valid"}, 32'(bus.valid), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(elat));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(elat));
    check({name, "_quot"}, 32'(bus.quotient), 32'(eq));
    check({name, "_rem"}, 32'(bus.remainder), 32'(er));
    check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(ed));
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_quot", 32'(bus.quotient), 32'd0);
    check("rst_rem", 32'(bus.remainder), 32'd0);
    rst_n = 1'b1;
    tick();

    issue(1'b0, 8'd200, 8'd7);  wait_result("u200_7", 8'd28, 8'd4, 1'b0, 9, -1, -1);
    issue(1'b1, 8'hF9, 8'h02);  wait_result("s_f9_02", 8'hFD, 8'hFF, 1'b0, 9, -1, -1);
    issue(1'b0, 8'hF9, 8'h02);  wait_result("u_f9_02", 8'd124, 8'd1, 1'b0, 9, -1, -1);
    issue(1'b1, 8'h07, 8'hFE);  wait_result("s_07_fe", 8'hFD, 8'h01, 1'b0, 9, -1, -1);
    issue(1'b1, 8'h80, 8'hFF);  wait_result("s_ovf", 8'h80, 8'h00, 1'b0, 9, -1, -1);
    issue(1'b0, 8'h35, 8'h00);  wait_result("dbz_u", 8'hFF, 8'h35, 1'b1, DBZ_LAT, -1, -1);
    issue(1'b1, 8'hF0, 8'h00);  wait_result("dbz_s", 8'hFF, 8'hF0, 1'b1, DBZ_LAT, -1, -1);
    issue(1'b0, 8'd200, 8'd7);  wait_result("stall", 8'd28, 8'd4, 1'b0, 12, 3, -1);
    issue(1'b1, 8'hF9, 8'h02);  wait_result("poke", 8'hFD, 8'hFF, 1'b0, 9, -1, 4);

    // Start on the valid cycle of the previous result.
    issue(1'b0, 8'd100, 8'd10); wait_result("b2b_a", 8'd10, 8'd0, 1'b0, 9, -1, -1);
    issue(1'b1, 8'h80, 8'h02);  wait_result("b2b_b", 8'hC0, 8'h00, 1'b0, 9, -1, -1);

    // A high valid is frozen while enable is low.
    bus.enable = 1'b0;
    tick();
    tick();
    check("hold_valid", 32'(bus.valid), 32'd1);
    check("hold_quot", 32'(bus.quotient), 32'hC0);
    bus.enable = 1'b1;
    tick();
    check("hold_release_valid", 32'(bus.valid), 32'd0);

    // Asynchronous reset in the middle of an operation.
    issue(1'b0, 8'd200, 8'd7);
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_valid", 32'(bus.valid), 32'd0);
    check("arst_quot", 32'(bus.quotient), 32'd0);
    check("arst_rem", 32'(bus.remainder), 32'd0);
    check("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 8'd100, 8'd10); wait_result("post_rst", 8'd10, 8'd0, 1'b0, 9, -1, -1);

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
